// File: rtl/param_shift_unit.sv
// Registered WIDTH-bit shift/rotate unit with load, clear and hold commands.
// Shift and rotate commands advance one bit per clock, with a busy/done handshake.
module param_shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_msb,
   output logic             ser_out_lsb,
   output logic             carry_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;

   logic [2:0]       step_op;
   logic [WIDTH-1:0] step_q;
   logic             step_c;

   // The step logic follows the latched op while a multi-step command runs.
   assign step_op = (state_q == SHIFT) ? op_q : op;

   always_comb begin
      step_q = q_q;
      step_c = carry_q;
      unique case (step_op)
         3'b001: begin
            step_q = {q_q[WIDTH-2:0], ser_in_r};
            step_c = q_q[WIDTH-1];
         end
         3'b010: begin
            step_q = {ser_in_l, q_q[WIDTH-1:1]};
            step_c = q_q[0];
         end
         3'b101: begin
            step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            step_c = q_q[WIDTH-1];
         end
         3'b110: begin
            step_q = {q_q[0], q_q[WIDTH-1:1]};
            step_c = q_q[0];
         end
         3'b111: begin
            step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            step_c = q_q[0];
         end
         default: begin
            step_q = q_q;
            step_c = carry_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            op_d   = op;
            done_d = 1'b1;
            unique case (op)
               3'b000: q_d = q_q;
               3'b011: begin
                  q_d     = '0;
                  carry_d = 1'b0;
               end
               3'b100: q_d = data_in;
               default: begin
                  if (amount != '0) begin
                     q_d     = step_q;
                     carry_d = step_c;
                  end
                  if (amount > AMT_W'(1)) begin
                     state_d = SHIFT;
                     cnt_d   = amount - AMT_W'(1);
                     done_d  = 1'b0;
                  end
               end
            endcase
         end
      end else begin
         q_d     = step_q;
         carry_d = step_c;
         cnt_d   = cnt_q - AMT_W'(1);
         if (cnt_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         op_q    <= 3'b000;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign q           = q_q;
   assign ser_out_msb = q_q[WIDTH-1];
   assign ser_out_lsb = q_q[0];
   assign carry_out   = carry_q;
   assign busy        = (state_q == SHIFT);
   assign done        = done_q;

endmodule
